score_serializer: RTL and testbench

SCORE_SERIALIZER -- requirements
Module: score_serializer

---
 rtl/nn_pkg.sv | 13 +
 rtl/score_serializer.sv | 120 ++++++++++++
 tb/tb_score_serializer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared FSM state type and default sizing for the score output stage
package nn_pkg;

  localparam int NN_NEURON_NB = 10;
  localparam int NN_WIDTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_FINISH = 2'd2
  } ser_state_e;

endpackage

// File: rtl/score_serializer.sv
// rtl/score_serializer.sv - captures a frame of last-layer scores and streams them out one per transfer
module score_serializer
  import nn_pkg::*;
#(
  parameter int NEURON_NB = NN_NEURON_NB,
  parameter int WIDTH     = NN_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [2*WIDTH-1:0] in_data [0:NEURON_NB-1],
  output logic                      busy,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [2*WIDTH-1:0] m_data,
  output logic [WIDTH-1:0]          m_index,
  output logic                      m_last,
  output logic                      done
);

  localparam int               CNT_W    = $clog2(NEURON_NB + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NEURON_NB - 1);

  generate
    if (NEURON_NB < 1 || NEURON_NB > 2**WIDTH) begin : g_bad_neuron_nb
      $error("score_serializer: NEURON_NB must lie in 1..2**WIDTH");
    end
  endgenerate

  ser_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [2*WIDTH-1:0] buf_q [0:NEURON_NB-1];
  logic signed [2*WIDTH-1:0] sel_data;
  logic                      capture;
  logic                      xfer;
  logic                      at_last;

  assign capture = (state_q == ST_IDLE) && start;
  assign xfer    = (state_q == ST_SEND) && m_ready;
  assign at_last = (cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEND;
      ST_SEND:   if (xfer && at_last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The counter parks on the last index so it can never wrap inside a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (capture) begin
      cnt_d = '0;
    end else if (xfer && !at_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int k = 0; k < NEURON_NB; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (capture) begin
        for (int k = 0; k < NEURON_NB; k++) begin
          buf_q[k] <= in_data[k];
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NEURON_NB; k++) begin
      if (cnt_q == CNT_W'(k)) sel_data = buf_q[k];
    end
  end

  // Outputs are masked by reset so they read zero during the reset cycle itself.
  always_comb begin
    busy    = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    done    = 1'b0;
    m_data  = '0;
    m_index = '0;
    if (!reset) begin
      case (state_q)
        ST_SEND: begin
          busy    = 1'b1;
          m_valid = 1'b1;
          m_last  = at_last;
          m_data  = sel_data;
          m_index = WIDTH'(cnt_q);
        end
        ST_FINISH: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_serializer.sv
// tb/tb_score_serializer.sv - scoreboard bench for score_serializer with randomized frames and backpressure
module tb_score_serializer;

  localparam int NB = 10;
  localparam int W  = 8;

  typedef struct {
    logic signed [2*W-1:0] data;
    logic [W-1:0]          idx;
    logic                  last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  m_ready;
  logic                  busy;
  logic                  m_valid;
  logic                  m_last;
  logic                  done;
  logic signed [2*W-1:0] in_data [0:NB-1];
  logic signed [2*W-1:0] m_data;
  logic [W-1:0]          m_index;

  logic signed [2*W-1:0] model [0:NB-1];
  exp_t                  exp_q [$];
  logic signed [2*W-1:0] rx_q [$];

  int total      = 0;
  int bad        = 0;
  int done_seen  = 0;
  int frames_exp = 0;
  int ready_mode = 0;
  int ready_phase = 0;

  score_serializer #(.NEURON_NB(NB), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_data (in_data),
    .busy    (busy),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Downstream ready: 0 = always accept, 1 = repeating 1,0,0 pattern, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (ready_phase % 3 == 0);
          ready_phase++;
        end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic                  stall_prev = 1'b0;
  logic                  last_prev  = 1'b0;
  logic signed [2*W-1:0] hold_data;
  logic [W-1:0]          hold_idx;
  logic                  hold_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
        last_prev  = 1'b0;
      end else begin
        if (done || last_prev) begin
          chk("done_after_last", done, last_prev);
          if (done) done_seen++;
        end
        if (stall_prev) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, hold_data);
          chk("stall_index", m_index, hold_idx);
          chk("stall_last", m_last, hold_last);
        end
        last_prev = 1'b0;
        if (m_valid && m_ready) begin
          chk("element_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("xfer_data", m_data, e.data);
            chk("xfer_index", m_index, e.idx);
            chk("xfer_last", m_last, e.last);
            rx_q.push_back(m_data);
            last_prev = m_last;
          end
        end
        stall_prev = m_valid && !m_ready;
        hold_data  = m_data;
        hold_idx   = m_index;
        hold_last  = m_last;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) in_data[k] = model[k];
    start = 1'b1;
    rx_q.delete();
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back('{data: model[k], idx: W'(k), last: (k == NB - 1)});
    end
    frames_exp++;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_valid", m_valid, 1);
    chk("lat_index", m_index, 0);
    chk("lat_busy", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_seen", done, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic rand_model();
    for (int k = 0; k < NB; k++) model[k] = 16'($urandom);
  endtask

  initial begin
    int n;
    int am_model;
    int am_rx;
    int pos_min;
    int pos_max;

    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < NB; k++) in_data[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Basic frame, always ready: ten back-to-back elements then done.
    ready_mode = 0;
    model[0] = 5;  model[1] = -3; model[2] = 7; model[3] = 0; model[4] = 12;
    model[5] = -1; model[6] = 9;  model[7] = 2; model[8] = 2; model[9] = 4;
    start_frame();
    wait_done(n);
    chk("basic_len", n, NB);

    // Backpressure pattern 1,0,0.
    ready_phase = 0;
    ready_mode  = 1;
    rand_model();
    start_frame();
    wait_done(n);

    // Capture isolation: inputs change right after the start is taken.
    ready_mode = 2;
    rand_model();
    start_frame();
    #1;
    for (int k = 0; k < NB; k++) in_data[k] = -16'sd128;
    wait_done(n);

    // Start pulsed mid-frame must be ignored.
    ready_mode = 0;
    rand_model();
    start_frame();
    repeat (4) @(negedge clk);
    chk("ignored_at_index", m_index, 4);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);

    // Reset while index 6 is presented.
    rand_model();
    start_frame();
    repeat (6) @(negedge clk);
    chk("pre_rst_index", m_index, 6);
    chk("pre_rst_valid", m_valid, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_last", m_last, 0);
    chk("abort_done", done, 0);
    chk("abort_data", m_data, 0);
    chk("abort_index", m_index, 0);
    exp_q.delete();
    frames_exp--;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    rand_model();
    start_frame();
    wait_done(n);

    // Sign extremes and golden argmax over the received stream.
    ready_mode = 2;
    rand_model();
    for (int k = 0; k < NB; k++) if (model[k] == 16'sh7fff) model[k] = 0;
    pos_min = $urandom_range(0, NB - 1);
    pos_max = (pos_min + 1 + $urandom_range(0, NB - 2)) % NB;
    model[pos_min] = -16'sd32768;
    model[pos_max] = 16'sd32767;
    start_frame();
    wait_done(n);
    am_model = pos_max;
    am_rx = 0;
    for (int k = 1; k < rx_q.size(); k++) if (rx_q[k] > rx_q[am_rx]) am_rx = k;
    chk("rx_count", rx_q.size(), NB);
    chk("argmax", am_rx, am_model);

    // Random frames, each started back-to-back right after the previous done.
    for (int f = 0; f < 6; f++) begin
      ready_mode = (f % 2 == 0) ? 2 : 0;
      rand_model();
      start_frame();
      wait_done(n);
    end

    repeat (3) @(negedge clk);
    chk("done_count", done_seen, frames_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
